datapath_gen: RTL
=================

# datapath_gen

Parametrised successor to the fixed 16-bit, 8-register multicycle datapath. It executes one micro-op at a time, issued by the external controller over a valid/ready handshake, and signals completion. Width and register count are generic. Shifts are multi-cycle and memory access uses a req/ack handshake, so the datapath itself owns all wait states and the controller no longer times memory or shift cycles.

## Interface
Parameters:
- `WIDTH`, 16, datapath, register, PC and memory word width (≥8, power of 2)
- `NREG`, 8, register count (power of 2, ≥2); `RAW` = log2(NREG)
- `RESET_PC`, 0, PC value after reset

Ports:
- `clk` in 1, single clock; all state changes on rising edge
- `reset` in 1, synchronous, active-high
- `uop_valid` in 1, micro-op offered
- `uop_ready` out 1, high only in IDLE
- `uop_op` in 4, micro-op code
- `uop_sr1`, `uop_sr2`, `uop_dr` in RAW, source/destination register indices
- `uop_imm` in WIDTH, pre-extended immediate/offset
- `uop_src2_imm` in 1, operand B = `uop_imm` (1) or R[sr2] (0)
- `uop_set_cc` in 1, update n/z/p from result
- `uop_nzp` in 3, branch mask {n,z,p}
- `uop_done` out 1, one-cycle completion pulse
- `mem_req`, `mem_we` out 1; `mem_addr`, `mem_wdata` out WIDTH; `mem_ack` in 1; `mem_rdata` in WIDTH
- `pc`, `ir` out WIDTH; `n`, `z`, `p` out 1
- `dbg_sel` in RAW; `dbg_val` out WIDTH, combinational R[dbg_sel]

## Operation
- Handshake: the uop is accepted at an edge where `uop_valid` and `uop_ready` are both high. All `uop_*` fields are sampled only at that edge. A = R[sr1] and B are latched at the same edge.
- States: IDLE → EXEC → (SHIFT | MEM)? → IDLE.
- Ops:
  - 0 NOP
  - 1 ADD
  - 2 AND
  - 3 NOT A
  - 4 PASS B
  - 5 SHL
  - 6 SHR (logical)
  - 7 SRA
  - 8 LD: R[dr] = M[A+B]
  - 9 ST: M[A+B] = R[dr]
  - 10 FETCH: IR = M[PC], PC = PC+1
  - 11 BR: if (`uop_nzp` & {n,z,p}) ≠ 0, PC = PC+imm
  - 12 JMP: PC = A
  - 13 JSR: R[NREG-1] = PC, PC = PC+imm
  - 14–15 behave as NOP
- Arithmetic is modulo 2^WIDTH; carry is discarded.
- Shift amount = B[log2(WIDTH)-1:0]; upper bits are ignored.
- Condition codes, when `uop_set_cc` is high on ops 1–8: z = result==0; n = result MSB; p = otherwise. Exactly one of n/z/p is set. Ops 0 and 9–15 never touch the condition codes.
- Register writes occur only at completion. A write to R[dr] and a simultaneous debug read of the same register returns the old value in that cycle.

## Timing
- Reset values: all registers 0, `pc`=RESET_PC, `ir`=0, z=1, n=p=0, state IDLE, `uop_ready`=1 (after reset deasserts), `uop_done`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=`mem_wdata`=0.
- Edge numbering: acceptance at edge E0.
- Ops 0–4 and 11–15: writeback at E1. `uop_done` is high in the cycle after E1, and `uop_ready` is high again in that same cycle.
- Shifts (serial): one bit per SHIFT cycle. Writeback at E1+s, where s = amount. s=0 behaves like ADD.
- Memory ops (8–10):
  - `mem_req` rises in the cycle after E0.
  - `mem_addr`/`mem_we`/`mem_wdata` are stable until the edge at which `mem_ack` is sampled high.
  - That edge performs the writeback (LD reg/CC, FETCH IR/PC). `mem_req` drops in the next cycle.
  - `mem_ack` is ignored while `mem_req` is low.
  - Zero-wait memory (ack already high in the first req cycle) completes at E2.
- Reset mid-operation: abort without writeback; `mem_req` is low in the cycle after the reset edge.
- `uop_valid` while busy is ignored, not queued.

## Configuration
- `DATAPATH_GEN_BARREL_EN`:
  - Defined: shifts use a combinational barrel shifter, complete in EXEC, and have ADD timing for every amount.
  - Undefined: shifts use the serial SHIFT state described above.
  - Results and condition codes are identical either way.

## Test plan
- Reset, then ADD R1=R0+imm 5 with set_cc → R1=5, p=1; done pulse in the cycle after E1; `dbg_val`(sel=1)=5.
- WIDTH=16: R2=0x8001, SRA by 3 → 0xF000, n=1. Serial: writeback at E4. Barrel: writeback at E1.
- LD with ack delayed 3 cycles → `mem_req` held 3 cycles with stable `mem_addr`=A+imm; R[dr]=`mem_rdata` at the ack edge. Zero-wait case completes at E2.
- FETCH at PC=0x3000, rdata=0x1234 → IR=0x1234, PC=0x3001. BR nzp=010 with z=1, imm=-2 → PC=0x2FFF. With mask 100 → PC unchanged.
- Reset asserted during ST wait → no write completes, `mem_req`=0 the following cycle, PC=RESET_PC, registers 0.
- Back-to-back `uop_valid` held high → one acceptance per completion; ops 14/15 complete as NOP with condition codes unchanged.

Source files
------------

// File: rtl/datapath_gen.sv
// datapath_gen: parametrised multicycle micro-op datapath with valid/ready issue and a req/ack memory port.
// Optional feature: define DATAPATH_GEN_BARREL_EN for single-cycle barrel shifts (default: serial shifter).
module datapath_gen #(
   parameter int               WIDTH    = 16,
   parameter int               NREG     = 8,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   // Issue handshake: a micro-op is accepted on a rising edge where uop_valid and uop_ready are
   // both high; every uop_* field is sampled only at that edge and uop_ready is high only in IDLE.
   input  logic                     uop_valid,
   output logic                     uop_ready,
   input  logic [3:0]               uop_op,
   input  logic [$clog2(NREG)-1:0]  uop_sr1,
   input  logic [$clog2(NREG)-1:0]  uop_sr2,
   input  logic [$clog2(NREG)-1:0]  uop_dr,
   input  logic [WIDTH-1:0]         uop_imm,
   input  logic                     uop_src2_imm,
   input  logic                     uop_set_cc,
   input  logic [2:0]               uop_nzp,
   output logic                     uop_done,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [WIDTH-1:0]         mem_addr,
   output logic [WIDTH-1:0]         mem_wdata,
   input  logic                     mem_ack,
   input  logic [WIDTH-1:0]         mem_rdata,
   output logic [WIDTH-1:0]         pc,
   output logic [WIDTH-1:0]         ir,
   output logic                     n,
   output logic                     z,
   output logic                     p,
   input  logic [$clog2(NREG)-1:0]  dbg_sel,
   output logic [WIDTH-1:0]         dbg_val
);

   localparam int RAW = $clog2(NREG);
   localparam int SW  = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_EXEC  = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_MEM   = 2'd3;

   localparam logic [3:0] OP_ADD   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_NOT   = 4'd3;
   localparam logic [3:0] OP_PASS  = 4'd4;
   localparam logic [3:0] OP_SHL   = 4'd5;
   localparam logic [3:0] OP_SHR   = 4'd6;
   localparam logic [3:0] OP_SRA   = 4'd7;
   localparam logic [3:0] OP_LD    = 4'd8;
   localparam logic [3:0] OP_ST    = 4'd9;
   localparam logic [3:0] OP_FETCH = 4'd10;
   localparam logic [3:0] OP_BR    = 4'd11;
   localparam logic [3:0] OP_JMP   = 4'd12;
   localparam logic [3:0] OP_JSR   = 4'd13;

   logic [1:0]       state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [RAW-1:0]   dr_q, dr_d;
   logic [WIDTH-1:0] imm_q, imm_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             set_cc_q, set_cc_d;
   logic [2:0]       nzp_q, nzp_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] ir_q, ir_d;
   logic [2:0]       cc_q, cc_d;
   logic             done_q, done_d;
   logic             mem_req_q, mem_req_d;
   logic             mem_we_q, mem_we_d;
   logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [WIDTH-1:0] regs_q [NREG];
   logic [WIDTH-1:0] regs_d [NREG];
`ifndef DATAPATH_GEN_BARREL_EN
   logic [SW-1:0]    cnt_q, cnt_d;
`endif

   logic [WIDTH-1:0] a_in, b_in, alu_res, wb_val;
   logic [SW-1:0]    sh_amt;
   logic [RAW-1:0]   wb_idx;
   logic             wb_en, cc_upd, is_mem_op;

   // cc is packed {n, z, p}; exactly one bit is set.
   function automatic logic [2:0] cc_of(input logic [WIDTH-1:0] v);
      logic zero;
      zero = (v == '0);
      return {v[WIDTH-1], zero, ~v[WIDTH-1] & ~zero};
   endfunction

`ifndef DATAPATH_GEN_BARREL_EN
   function automatic logic [WIDTH-1:0] shift_one(input logic [3:0] op, input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      case (op)
         OP_SHL:  r = {v[WIDTH-2:0], 1'b0};
         OP_SHR:  r = {1'b0, v[WIDTH-1:1]};
         default: r = {v[WIDTH-1], v[WIDTH-1:1]};
      endcase
      return r;
   endfunction
`endif

   assign a_in      = regs_q[uop_sr1];
   assign b_in      = uop_src2_imm ? uop_imm : regs_q[uop_sr2];
   assign is_mem_op = (uop_op == OP_LD) || (uop_op == OP_ST) || (uop_op == OP_FETCH);
   assign sh_amt    = b_q[SW-1:0];

   always_comb begin
      alu_res = b_q;
      case (op_q)
         OP_ADD: alu_res = a_q + b_q;
         OP_AND: alu_res = a_q & b_q;
         OP_NOT: alu_res = ~a_q;
`ifdef DATAPATH_GEN_BARREL_EN
         OP_SHL: alu_res = a_q << sh_amt;
         OP_SHR: alu_res = a_q >> sh_amt;
         OP_SRA: alu_res = $signed(a_q) >>> sh_amt;
`else
         // Zero-amount shifts finish in EXEC and simply pass A through.
         OP_SHL, OP_SHR, OP_SRA: alu_res = a_q;
`endif
         default: alu_res = b_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      dr_d        = dr_q;
      imm_d       = imm_q;
      a_d         = a_q;
      b_d         = b_q;
      set_cc_d    = set_cc_q;
      nzp_d       = nzp_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      cc_d        = cc_q;
      done_d      = 1'b0;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
`ifndef DATAPATH_GEN_BARREL_EN
      cnt_d       = cnt_q;
`endif
      wb_en       = 1'b0;
      wb_idx      = dr_q;
      wb_val      = alu_res;
      cc_upd      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (uop_valid) begin
               state_d  = S_EXEC;
               op_d     = uop_op;
               dr_d     = uop_dr;
               imm_d    = uop_imm;
               a_d      = a_in;
               b_d      = b_in;
               set_cc_d = uop_set_cc;
               nzp_d    = uop_nzp;
               // Memory request is registered here so it is visible in the cycle after acceptance.
               if (is_mem_op) begin
                  mem_req_d   = 1'b1;
                  mem_we_d    = (uop_op == OP_ST);
                  mem_addr_d  = (uop_op == OP_FETCH) ? pc_q : a_in + b_in;
                  mem_wdata_d = (uop_op == OP_ST) ? regs_q[uop_dr] : '0;
               end
            end
         end
         S_EXEC: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            case (op_q)
               OP_ADD, OP_AND, OP_NOT, OP_PASS: begin
                  wb_en  = 1'b1;
                  cc_upd = set_cc_q;
               end
               OP_SHL, OP_SHR, OP_SRA: begin
`ifdef DATAPATH_GEN_BARREL_EN
                  wb_en  = 1'b1;
                  cc_upd = set_cc_q;
`else
                  if (sh_amt != '0) begin
                     state_d = S_SHIFT;
                     done_d  = 1'b0;
                     cnt_d   = sh_amt;
                  end else begin
                     wb_en  = 1'b1;
                     cc_upd = set_cc_q;
                  end
`endif
               end
               OP_LD, OP_ST, OP_FETCH: begin
                  // The ack is only sampled from MEM onwards, so zero-wait memory completes one edge later.
                  state_d = S_MEM;
                  done_d  = 1'b0;
               end
               OP_BR: begin
                  if ((nzp_q & cc_q) != 3'b000) pc_d = pc_q + imm_q;
               end
               OP_JMP: pc_d = a_q;
               OP_JSR: begin
                  wb_en  = 1'b1;
                  wb_idx = RAW'(NREG - 1);
                  wb_val = pc_q;
                  pc_d   = pc_q + imm_q;
               end
               default: ;
            endcase
         end
         S_SHIFT: begin
`ifdef DATAPATH_GEN_BARREL_EN
            state_d = S_IDLE;
`else
            a_d   = shift_one(op_q, a_q);
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == SW'(1)) begin
               wb_en   = 1'b1;
               wb_val  = a_d;
               cc_upd  = set_cc_q;
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
`endif
         end
         S_MEM: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               state_d   = S_IDLE;
               done_d    = 1'b1;
               if (op_q == OP_LD) begin
                  wb_en  = 1'b1;
                  wb_val = mem_rdata;
                  cc_upd = set_cc_q;
               end else if (op_q == OP_FETCH) begin
                  ir_d = mem_rdata;
                  pc_d = pc_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (cc_upd) cc_d = cc_of(wb_val);
      regs_d = regs_q;
      if (wb_en) regs_d[wb_idx] = wb_val;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         dr_q        <= '0;
         imm_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         set_cc_q    <= 1'b0;
         nzp_q       <= '0;
         pc_q        <= RESET_PC;
         ir_q        <= '0;
         cc_q        <= 3'b010;
         done_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
`ifndef DATAPATH_GEN_BARREL_EN
         cnt_q       <= '0;
`endif
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         dr_q        <= dr_d;
         imm_q       <= imm_d;
         a_q         <= a_d;
         b_q         <= b_d;
         set_cc_q    <= set_cc_d;
         nzp_q       <= nzp_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         cc_q        <= cc_d;
         done_q      <= done_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
`ifndef DATAPATH_GEN_BARREL_EN
         cnt_q       <= cnt_d;
`endif
         regs_q      <= regs_d;
      end
   end

   assign uop_ready = (state_q == S_IDLE);
   assign uop_done  = done_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign pc        = pc_q;
   assign ir        = ir_q;
   assign n         = cc_q[2];
   assign z         = cc_q[1];
   assign p         = cc_q[0];
   assign dbg_val   = regs_q[dbg_sel];

endmodule
